instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of program_memory: owns the program counter, drives

---
 rtl/instruction_fetch_pkg.sv | 30 +++
 rtl/instruction_fetch_if.sv | 43 ++++
 rtl/instruction_fetch_pc_next_sel.sv | 33 +++
 rtl/instruction_fetch.sv | 114 +++++++++++
 tb/tb_instruction_fetch.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: program geometry, opcode encoding,
// jump-target field placement and the fetch FSM state type.
package instruction_fetch_pkg;

    localparam int BITS_FOR_INSTRUCTIONS  = 5;
    localparam int INSTRUCTION_WIDTH      = 16;
    localparam int NUMBER_OF_INSTRUCTIONS = 32;

    localparam int OPCODE_WIDTH    = 4;
    localparam int JUMP_TARGET_LSB = 4;

    localparam logic [BITS_FOR_INSTRUCTIONS-1:0] LAST_ADDR =
        BITS_FOR_INSTRUCTIONS'(NUMBER_OF_INSTRUCTIONS - 1);

    typedef enum logic [OPCODE_WIDTH-1:0] {
        NOP,
        ADD,
        LOAD,
        JUMP,
        STOREMEM,
        STORERF
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: program-memory read port, execute redirect and the
// valid/ready issue port towards the decoder.
interface instruction_fetch_if #(
    parameter int B = instruction_fetch_pkg::BITS_FOR_INSTRUCTIONS,
    parameter int W = instruction_fetch_pkg::INSTRUCTION_WIDTH
) ();
    logic         start;
    logic [B-1:0] instruction_address;
    logic [W-1:0] instruction;
    logic         redirect_valid;
    logic [B-1:0] redirect_addr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_instr;
    logic [B-1:0] out_pc;
    logic         halted;

    modport master (
        input  start,
        input  instruction,
        input  redirect_valid,
        input  redirect_addr,
        input  out_ready,
        output instruction_address,
        output out_valid,
        output out_instr,
        output out_pc,
        output halted
    );

    modport slave (
        output start,
        output instruction,
        output redirect_valid,
        output redirect_addr,
        output out_ready,
        input  instruction_address,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  halted
    );
endinterface

// File: rtl/instruction_fetch_pc_next_sel.sv
// Combinational next-PC selection: redirect beats jump beats sequential
// increment; the increment wraps at the last program address.
module instruction_fetch_pc_next_sel
    import instruction_fetch_pkg::*;
(
    input  logic [BITS_FOR_INSTRUCTIONS-1:0] pc_i,
    input  logic [OPCODE_WIDTH-1:0]          opcode_i,
    input  logic [BITS_FOR_INSTRUCTIONS-1:0] jump_target_i,
    input  logic                             redirect_valid_i,
    input  logic [BITS_FOR_INSTRUCTIONS-1:0] redirect_addr_i,
    output logic [BITS_FOR_INSTRUCTIONS-1:0] next_pc_o
);

    logic [BITS_FOR_INSTRUCTIONS-1:0] redirect_tgt;
    logic [BITS_FOR_INSTRUCTIONS-1:0] seq_pc;

    // Out-of-range redirect targets fold back into the program; identity when
    // the program fills the whole address space.
    assign redirect_tgt = BITS_FOR_INSTRUCTIONS'(32'(redirect_addr_i) % 32'(NUMBER_OF_INSTRUCTIONS));

    assign seq_pc = (pc_i == LAST_ADDR) ? '0 : pc_i + 1'b1;

    // Priority mux for the next fetch address.
    always_comb begin
        next_pc_o = seq_pc;
        if (redirect_valid_i) begin
            next_pc_o = redirect_tgt;
        end else if (opcode_i == JUMP) begin
            next_pc_o = jump_target_i;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads program memory combinationally and issues
// one registered instruction per cycle to the decoder over valid/ready.
// Optional feature macro: IFETCH_HALT_AT_END_EN (halt after issuing the last
// program address instead of wrapping to 0).
//
// state | meaning
// IDLE  | waiting for start, no fetch
// RUN   | fetching and issuing
// HALT  | last instruction issued, fetch stopped until reset
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
);

    fetch_state_t                     state_q, state_d;
    logic [BITS_FOR_INSTRUCTIONS-1:0] pc_q, pc_d;
    logic                             out_valid_q, out_valid_d;
    logic [INSTRUCTION_WIDTH-1:0]     out_instr_q, out_instr_d;
    logic [BITS_FOR_INSTRUCTIONS-1:0] out_pc_q, out_pc_d;

    logic [BITS_FOR_INSTRUCTIONS-1:0] next_pc;
    logic                             load;

    instruction_fetch_pc_next_sel u_pc_next_sel (
        .pc_i             (pc_q),
        .opcode_i         (bus.instruction[OPCODE_WIDTH-1:0]),
        .jump_target_i    (bus.instruction[JUMP_TARGET_LSB +: BITS_FOR_INSTRUCTIONS]),
        .redirect_valid_i (bus.redirect_valid),
        .redirect_addr_i  (bus.redirect_addr),
        .next_pc_o        (next_pc)
    );

    // The output register may take a new word when it is empty or being drained.
    assign load = (state_q == RUN) && (!out_valid_q || bus.out_ready);

`ifdef IFETCH_HALT_AT_END_EN
    logic halt_on_load;
    // A jump at the last address still redirects, so only a sequential step halts.
    assign halt_on_load = (pc_q == LAST_ADDR) && (bus.instruction[OPCODE_WIDTH-1:0] != JUMP);
`endif

    // Fetch FSM next-state and datapath next values.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        // Accepted word with nothing to replace it empties the register.
        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    // Flush: drop whatever is held and fetch from the new target.
                    pc_d        = next_pc;
                    out_valid_d = 1'b0;
                end else if (load) begin
                    out_instr_d = bus.instruction;
                    out_pc_d    = pc_q;
                    out_valid_d = 1'b1;
                    pc_d        = next_pc;
`ifdef IFETCH_HALT_AT_END_EN
                    if (halt_on_load) begin
                        state_d = HALT;
                        pc_d    = pc_q;
                    end
`endif
                end
            end
            default: begin
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign bus.instruction_address = pc_q;
    assign bus.out_valid           = out_valid_q;
    assign bus.out_instr           = out_instr_q;
    assign bus.out_pc              = out_pc_q;
`ifdef IFETCH_HALT_AT_END_EN
    assign bus.halted              = (state_q == HALT);
`else
    assign bus.halted              = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: program memory model, reset, sequential
// issue, stall, jump, redirect and end-of-program behaviour (both macro builds).
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    logic [INSTRUCTION_WIDTH-1:0] mem [NUMBER_OF_INSTRUCTIONS];

    assign bus.instruction = mem[bus.instruction_address];

    instruction_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_pc(input logic [4:0] target, input int budget, input string tag);
        int n = 0;
        while (!(bus.out_valid === 1'b1 && bus.out_pc === target) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(bus.out_valid === 1'b1 && bus.out_pc === target), 32'd1);
    endtask

    initial begin
        // word = {addr, 7'd0, opcode}: NOP at 0, LOAD at 12, JUMP->20 at 13, ADD elsewhere
        for (int i = 0; i < NUMBER_OF_INSTRUCTIONS; i++) begin
            mem[i] = {5'(i), 7'd0, (i == 0) ? 4'd0 : ((i == 12) ? 4'd2 : 4'd1)};
        end
        mem[13] = 16'h0143;

        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.out_ready      = 1'b1;
        #12 rst = 1'b0;
        step();

        // reset state, and IDLE does not fetch
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_instr", 32'(bus.out_instr), 32'd0);
        chk("rst_pc", 32'(bus.out_pc), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_addr", 32'(bus.instruction_address), 32'd0);

        // sequential issue
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_empty", 32'(bus.out_valid), 32'd0);
        step();
        chk("seq0_valid", 32'(bus.out_valid), 32'd1);
        chk("seq0_pc", 32'(bus.out_pc), 32'd0);
        chk("seq0_instr", 32'(bus.out_instr), 32'h0000);
        step();
        chk("seq1_pc", 32'(bus.out_pc), 32'd1);
        chk("seq1_instr", 32'(bus.out_instr), 32'h0801);
        step();
        chk("seq2_valid", 32'(bus.out_valid), 32'd1);
        chk("seq2_pc", 32'(bus.out_pc), 32'd2);
        chk("seq2_instr", 32'(bus.out_instr), 32'h1001);

        // three-cycle stall at out_pc 5
        wait_out_pc(5'd5, 16, "reach_pc5");
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc", 32'(bus.out_pc), 32'd5);
            chk("stall_instr", 32'(bus.out_instr), 32'h2801);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_addr", 32'(bus.instruction_address), 32'd6);
        end
        bus.out_ready = 1'b1;
        step();
        chk("unstall_pc6", 32'(bus.out_pc), 32'd6);
        step();
        chk("unstall_pc7", 32'(bus.out_pc), 32'd7);

        // jump at address 13 to 20
        wait_out_pc(5'd12, 16, "reach_pc12");
        chk("pc12_instr", 32'(bus.out_instr), 32'h6002);
        step();
        chk("jmp_pc13", 32'(bus.out_pc), 32'd13);
        chk("jmp_instr", 32'(bus.out_instr), 32'h0143);
        chk("jmp_addr", 32'(bus.instruction_address), 32'd20);
        step();
        chk("jmp_pc20", 32'(bus.out_pc), 32'd20);
        step();
        chk("jmp_pc21", 32'(bus.out_pc), 32'd21);

        // asynchronous reset between clock edges
        rst = 1'b1;
        #2;
        chk("async_valid", 32'(bus.out_valid), 32'd0);
        chk("async_instr", 32'(bus.out_instr), 32'd0);
        chk("async_pc", 32'(bus.out_pc), 32'd0);
        chk("async_addr", 32'(bus.instruction_address), 32'd0);
        #2;
        rst = 1'b0;
        step();
        chk("post_rst_idle", 32'(bus.out_valid), 32'd0);

        // redirect during stall at out_pc 4
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_out_pc(5'd4, 16, "reach_pc4");
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 5'd9;
        step();
        chk("redir_flush", 32'(bus.out_valid), 32'd0);
        chk("redir_addr", 32'(bus.instruction_address), 32'd9);
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        step();
        chk("redir_valid", 32'(bus.out_valid), 32'd1);
        chk("redir_pc9", 32'(bus.out_pc), 32'd9);
        chk("redir_instr", 32'(bus.out_instr), 32'h4801);
        step();
        chk("redir_pc10", 32'(bus.out_pc), 32'd10);

        // end of program
        wait_out_pc(5'd31, 64, "reach_pc31");
        chk("pc31_instr", 32'(bus.out_instr), 32'hF801);
`ifdef IFETCH_HALT_AT_END_EN
        chk("halt_flag", 32'(bus.halted), 32'd1);
        chk("halt_addr", 32'(bus.instruction_address), 32'd31);
        step();
        chk("halt_drain", 32'(bus.out_valid), 32'd0);
        chk("halt_flag2", 32'(bus.halted), 32'd1);
        chk("halt_addr2", 32'(bus.instruction_address), 32'd31);
        step();
        chk("halt_nofetch", 32'(bus.out_valid), 32'd0);
`else
        chk("nohalt_flag", 32'(bus.halted), 32'd0);
        step();
        chk("wrap_pc0", 32'(bus.out_pc), 32'd0);
        chk("wrap_valid", 32'(bus.out_valid), 32'd1);
        chk("wrap_halted", 32'(bus.halted), 32'd0);
        step();
        chk("wrap_pc1", 32'(bus.out_pc), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
